// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the CPU and the UART upload writer.
// Optional upload lock (CPU locked out during an upload session) is enabled by defining MEM_ARB_UPG_LOCK_EN.
module dmem_port_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              upg_req,
    input  logic              upg_we,
    input  logic [ADDR_W-1:0] upg_adr,
    input  logic [DATA_W-1:0] upg_wdata,
    output logic              upg_gnt,
    output logic              upg_rvalid,
    output logic [DATA_W-1:0] upg_rdata,
    input  logic              upg_lock,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_UPG} state_t;
    localparam logic SEL_CPU = 1'b0;
    localparam logic SEL_UPG = 1'b1;

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              cpu_gnt_q, cpu_gnt_d;
    logic              upg_gnt_q, upg_gnt_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              upg_rvalid_q, upg_rvalid_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_adr_q, ram_adr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    logic lock_active;
    logic eff_last;
    logic cpu_pend, upg_pend, pick_cpu, pick_upg;

`ifdef MEM_ARB_UPG_LOCK_EN
    logic lock_q;
    assign lock_active = upg_lock;
    // On the falling edge of the lock the CPU is owed the next tie.
    assign eff_last    = (lock_q & ~upg_lock) ? SEL_UPG : last_gnt_q;
`else
    assign lock_active = 1'b0 & upg_lock;
    assign eff_last    = last_gnt_q;
`endif

    // The granted port's own req is stale during its grant cycle, so it is not a new request.
    assign cpu_pend = cpu_req & (state_q != GNT_CPU) & ~lock_active;
    assign upg_pend = upg_req & (state_q != GNT_UPG);
    assign pick_cpu = cpu_pend & (~upg_pend | (eff_last == SEL_UPG));
    assign pick_upg = upg_pend & ~pick_cpu;

    always_comb begin
        state_d      = IDLE;
        last_gnt_d   = eff_last;
        cpu_gnt_d    = 1'b0;
        upg_gnt_d    = 1'b0;
        ram_en_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_adr_d    = '0;
        ram_wdata_d  = '0;
        cpu_rvalid_d = (state_q == GNT_CPU) & ~ram_we_q;
        upg_rvalid_d = (state_q == GNT_UPG) & ~ram_we_q;
        if (pick_cpu) begin
            state_d     = GNT_CPU;
            last_gnt_d  = SEL_CPU;
            cpu_gnt_d   = 1'b1;
            ram_en_d    = 1'b1;
            ram_we_d    = cpu_we;
            ram_adr_d   = cpu_adr;
            ram_wdata_d = cpu_wdata;
        end else if (pick_upg) begin
            state_d     = GNT_UPG;
            last_gnt_d  = SEL_UPG;
            upg_gnt_d   = 1'b1;
            ram_en_d    = 1'b1;
            ram_we_d    = upg_we;
            ram_adr_d   = upg_adr;
            ram_wdata_d = upg_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= IDLE;
            last_gnt_q   <= SEL_UPG;
            cpu_gnt_q    <= 1'b0;
            upg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            upg_rvalid_q <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_adr_q    <= '0;
            ram_wdata_q  <= '0;
`ifdef MEM_ARB_UPG_LOCK_EN
            lock_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            cpu_gnt_q    <= cpu_gnt_d;
            upg_gnt_q    <= upg_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            upg_rvalid_q <= upg_rvalid_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_adr_q    <= ram_adr_d;
            ram_wdata_q  <= ram_wdata_d;
`ifdef MEM_ARB_UPG_LOCK_EN
            lock_q       <= upg_lock;
`endif
        end
    end

    assign cpu_gnt    = cpu_gnt_q;
    assign upg_gnt    = upg_gnt_q;
    assign cpu_stall  = cpu_req & ~cpu_gnt_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign upg_rvalid = upg_rvalid_q;
    assign cpu_rdata  = cpu_rvalid_q ? ram_rdata : '0;
    assign upg_rdata  = upg_rvalid_q ? ram_rdata : '0;
    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_adr    = ram_adr_q;
    assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: per-port drivers push expected grants/read data,
// a negedge monitor pops and compares them; main process runs directed scenarios.
module tb_dmem_port_arbiter;

    typedef struct {
        logic        we;
        logic [13:0] adr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [13:0] cpu_adr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        upg_req, upg_we, upg_gnt, upg_rvalid, upg_lock;
    logic [13:0] upg_adr;
    logic [31:0] upg_wdata, upg_rdata;
    logic        ram_en, ram_we;
    logic [13:0] ram_adr;
    logic [31:0] ram_wdata, ram_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    op_t         cpu_ops[$], upg_ops[$], cpu_gexp[$], upg_gexp[$];
    logic [31:0] cpu_rexp[$], upg_rexp[$];
    int          cpu_lat, upg_lat, cpu_start, upg_start;
    logic        cpu_granted, upg_granted;

    logic [31:0] mem [0:16383];
    logic [31:0] rd_q = '0;

    dmem_port_arbiter #(.ADDR_W(14), .DATA_W(32)) dut (
        .clock(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .upg_req(upg_req), .upg_we(upg_we), .upg_adr(upg_adr), .upg_wdata(upg_wdata),
        .upg_gnt(upg_gnt), .upg_rvalid(upg_rvalid), .upg_rdata(upg_rdata), .upg_lock(upg_lock),
        .ram_en(ram_en), .ram_we(ram_we), .ram_adr(ram_adr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial for (int i = 0; i < 16384; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_adr] <= ram_wdata;
            else        rd_q <= mem[ram_adr];
        end
    end
    assign ram_rdata = rd_q;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // CPU requester: holds req until the grant cycle ends, then presents the next queued op.
    initial begin
        op_t o;
        cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_wdata = '0; cpu_granted = 0; cpu_lat = 0; cpu_start = 0;
        forever begin
            @(posedge clk); #1;
            if (cpu_req && cpu_granted) begin cpu_req = 0; cpu_granted = 0; end
            if (cpu_req) begin
                if (cpu_gnt) begin cpu_granted = 1; cpu_lat = cyc - cpu_start; end
                else if (cyc - cpu_start > 80) begin chk("cpu_gnt_timeout", 1, 0); cpu_req = 0; end
            end else if (cpu_ops.size() > 0) begin
                o = cpu_ops.pop_front();
                cpu_req = 1; cpu_we = o.we; cpu_adr = o.adr; cpu_wdata = o.wdata;
                cpu_gexp.push_back(o);
                if (!o.we) cpu_rexp.push_back(o.rdata);
                cpu_start = cyc;
            end
        end
    end

    initial begin
        op_t o;
        upg_req = 0; upg_we = 0; upg_adr = '0; upg_wdata = '0; upg_granted = 0; upg_lat = 0; upg_start = 0;
        forever begin
            @(posedge clk); #1;
            if (upg_req && upg_granted) begin upg_req = 0; upg_granted = 0; end
            if (upg_req) begin
                if (upg_gnt) begin upg_granted = 1; upg_lat = cyc - upg_start; end
                else if (cyc - upg_start > 80) begin chk("upg_gnt_timeout", 1, 0); upg_req = 0; end
            end else if (upg_ops.size() > 0) begin
                o = upg_ops.pop_front();
                upg_req = 1; upg_we = o.we; upg_adr = o.adr; upg_wdata = o.wdata;
                upg_gexp.push_back(o);
                if (!o.we) upg_rexp.push_back(o.rdata);
                upg_start = cyc;
            end
        end
    end

    // Monitor: one line per transaction, compares against scoreboard queues.
    logic prev_rst = 0, prev_cpu_rd = 0, prev_upg_rd = 0;
    always @(negedge clk) begin
        op_t  e;
        logic cur_cpu_rd, cur_upg_rd;
        cur_cpu_rd = 0; cur_upg_rd = 0;
        if (prev_rst) begin
            chk("reset_ctrl", {cpu_gnt, upg_gnt, cpu_rvalid, upg_rvalid, ram_en, ram_we}, 0);
            chk("reset_data", {ram_adr, ram_wdata} | {cpu_rdata, upg_rdata}, 0);
            if (prev_cpu_rd && cpu_rexp.size() > 0) void'(cpu_rexp.pop_front());
            if (prev_upg_rd && upg_rexp.size() > 0) void'(upg_rexp.pop_front());
        end else begin
            chk("cpu_rvalid_timing", cpu_rvalid, prev_cpu_rd);
            chk("upg_rvalid_timing", upg_rvalid, prev_upg_rd);
            if (cpu_rvalid) begin
                if (cpu_rexp.size() == 0) chk("cpu_rvalid_unexpected", 1, 0);
                else begin
                    $display("cyc %0d cpu rdata %08h", cyc, cpu_rdata);
                    chk("cpu_rdata", cpu_rdata, cpu_rexp.pop_front());
                end
            end
            if (upg_rvalid) begin
                if (upg_rexp.size() == 0) chk("upg_rvalid_unexpected", 1, 0);
                else begin
                    $display("cyc %0d upg rdata %08h", cyc, upg_rdata);
                    chk("upg_rdata", upg_rdata, upg_rexp.pop_front());
                end
            end
            if (cpu_gnt) begin
                if (cpu_gexp.size() == 0) chk("cpu_gnt_unexpected", 1, 0);
                else begin
                    e = cpu_gexp.pop_front();
                    $display("cyc %0d cpu gnt we=%0b adr=%04h wdata=%08h", cyc, ram_we, ram_adr, ram_wdata);
                    chk("cpu_gnt_access", {ram_en, ram_we, ram_adr, ram_wdata}, {1'b1, e.we, e.adr, e.wdata});
                    cur_cpu_rd = ~e.we;
                end
            end
            if (upg_gnt) begin
                if (upg_gexp.size() == 0) chk("upg_gnt_unexpected", 1, 0);
                else begin
                    e = upg_gexp.pop_front();
                    $display("cyc %0d upg gnt we=%0b adr=%04h wdata=%08h", cyc, ram_we, ram_adr, ram_wdata);
                    chk("upg_gnt_access", {ram_en, ram_we, ram_adr, ram_wdata}, {1'b1, e.we, e.adr, e.wdata});
                    cur_upg_rd = ~e.we;
                end
            end
            chk("both_gnt", cpu_gnt & upg_gnt, 0);
            chk("cpu_stall", cpu_stall, cpu_req & ~cpu_gnt);
            if (!ram_en) chk("ram_idle_zero", {ram_we, ram_adr, ram_wdata}, 0);
        end
        prev_rst    = rst;
        prev_cpu_rd = cur_cpu_rd;
        prev_upg_rd = cur_upg_rd;
    end

    task automatic wait_idle();
        int n = 0;
        while (cpu_ops.size() > 0 || upg_ops.size() > 0 || cpu_req || upg_req) begin
            @(posedge clk); #2;
            n++;
            if (n > 300) begin chk("wait_idle_timeout", 1, 0); break; end
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    function automatic op_t mk(input logic we, input logic [13:0] adr, input logic [31:0] wd, input logic [31:0] rd);
        op_t o;
        o.we = we; o.adr = adr; o.wdata = wd; o.rdata = rd;
        return o;
    endfunction

    initial begin
        int c_cnt, u_cnt, en_cnt, alt_bad, stall_bad, n;
        logic prev_c;
        rst = 1; upg_lock = 0;
        repeat (3) @(posedge clk);
        #2 rst = 0;

        // Single CPU write then read.
        cpu_ops.push_back(mk(1, 14'h0010, 32'hDEADBEEF, 0));
        wait_idle();
        chk("t1_write_gnt_latency", cpu_lat, 1);
        cpu_ops.push_back(mk(0, 14'h0010, 0, 32'hDEADBEEF));
        wait_idle();
        chk("t1_read_gnt_latency", cpu_lat, 1);

        // Simultaneous first requests straight after reset.
        rst = 1;
        @(posedge clk); #2 rst = 0;
        cpu_ops.push_back(mk(0, 14'h0001, 0, 0));
        upg_ops.push_back(mk(1, 14'h0002, 32'h12345678, 0));
        wait_idle();
        chk("t2_cpu_first_latency", cpu_lat, 1);
        chk("t2_upg_second_latency", upg_lat, 2);

        // Both ports requesting continuously: 20-cycle window from the first grant.
        for (int i = 0; i < 12; i++) begin
            cpu_ops.push_back(mk(1, 14'h0020 + 14'(i), 32'hA0000000 + i, 0));
            upg_ops.push_back(mk(0, 14'h0002, 0, 32'h12345678));
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!(cpu_gnt || upg_gnt) && n < 10);
        c_cnt = 0; u_cnt = 0; en_cnt = 0; alt_bad = 0; prev_c = ~cpu_gnt;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            c_cnt += int'(cpu_gnt); u_cnt += int'(upg_gnt); en_cnt += int'(ram_en);
            if ((cpu_gnt == prev_c) || (cpu_gnt == upg_gnt)) alt_bad++;
            prev_c = cpu_gnt;
        end
        chk("t3_cpu_grants", c_cnt, 10);
        chk("t3_upg_grants", u_cnt, 10);
        chk("t3_ram_en_cycles", en_cnt, 20);
        chk("t3_alternation_errors", alt_bad, 0);
        wait_idle();

`ifdef MEM_ARB_UPG_LOCK_EN
        // Upload lock: CPU stalls while UPG gets every request, CPU wins the tie on release.
        upg_lock = 1;
        cpu_ops.push_back(mk(0, 14'h0020, 0, 32'hA0000000));
        for (int i = 0; i < 9; i++) upg_ops.push_back(mk(1, 14'h0040 + 14'(i), 32'h5A000000 + i, 0));
        c_cnt = 0; u_cnt = 0; stall_bad = 0; n = 0;
        while (u_cnt < 8 && n < 60) begin
            @(negedge clk); n++;
            c_cnt += int'(cpu_gnt); u_cnt += int'(upg_gnt);
            if (cpu_req && !cpu_stall) stall_bad++;
        end
        chk("t4_upg_grants_locked", u_cnt, 8);
        chk("t4_cpu_grants_locked", c_cnt, 0);
        chk("t4_stall_errors", stall_bad, 0);
        chk("t4_cpu_still_pending", cpu_req, 1);
        @(posedge clk); #2 upg_lock = 0;
        @(negedge clk);
        chk("t4_release_cpu_first", {cpu_gnt, upg_gnt}, 2'b10);
        @(negedge clk);
        chk("t4_release_upg_next", {cpu_gnt, upg_gnt}, 2'b01);
        wait_idle();
`else
        // Without the lock feature upg_lock is ignored: plain round-robin tie.
        upg_lock = 1;
        cpu_ops.push_back(mk(0, 14'h0020, 0, 32'hA0000000));
        upg_ops.push_back(mk(1, 14'h0040, 32'h5A000000, 0));
        wait_idle();
        chk("t4_lock_ignored_cpu_latency", cpu_lat, 1);
        chk("t4_lock_ignored_upg_latency", upg_lat, 2);
        upg_lock = 0;
`endif

        // Reset in the cycle of a CPU read grant.
        cpu_ops.push_back(mk(0, 14'h0010, 0, 32'hDEADBEEF));
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!cpu_gnt && n < 10);
        chk("t5_read_granted", cpu_gnt, 1);
        rst = 1;
        @(posedge clk); #2 rst = 0;
        @(negedge clk);
        chk("t5_rvalid_suppressed", cpu_rvalid, 0);
        cpu_ops.push_back(mk(0, 14'h0010, 0, 32'hDEADBEEF));
        wait_idle();
        chk("t5_post_reset_latency", cpu_lat, 1);

        chk("queues_drained", cpu_gexp.size() + upg_gexp.size() + cpu_rexp.size() + upg_rexp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
